// File: rtl/rb_alu_pkg.sv
// rb_alu_pkg: opcode constants and FSM state encoding shared by the ALU core and its bench
package rb_alu_pkg;
  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SBB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_SHL1 = 4'd9;
  localparam logic [3:0] OP_SHR1 = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_MOV  = 4'd13;
  localparam logic [3:0] OP_READ = 4'd14;
  localparam logic [3:0] OP_CMP  = 4'd15;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_WB} state_t;
endpackage

// File: rtl/rb_alu_if.sv
// rb_alu_if: request bus (start/opcode/rd/rs/imm/use_imm/cin) and result bus (busy/aluout/cb/zf/done)
interface rb_alu_if #(parameter int DW = 16, parameter int AW = 4);
  logic          start;
  logic [3:0]    opcode;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs;
  logic [DW-1:0] imm;
  logic          use_imm;
  logic          cin;
  logic          busy;
  logic [DW-1:0] aluout;
  logic          cb;
  logic          zf;
  logic          done;
  modport master (output start, opcode, rd, rs, imm, use_imm, cin, input busy, aluout, cb, zf, done);
  modport slave (input start, opcode, rd, rs, imm, use_imm, cin, output busy, aluout, cb, zf, done);
endinterface

// File: rtl/rb_regfile.sv
// rb_regfile: NREG x DW register file; clk/rst, two registered read ports (i_ra1/o_rd1, i_ra2/o_rd2), one sync write port (i_we/i_wa/i_wd)
module rb_regfile #(
  parameter int DW = 16,
  parameter int NREG = 16,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  output logic [DW-1:0] o_rd1,
  output logic [DW-1:0] o_rd2,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [DW-1:0] i_wd
);
  logic [DW-1:0] r_mem [NREG];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
      o_rd1 <= '0;
      o_rd2 <= '0;
    end else begin
      o_rd1 <= r_mem[i_ra1];
      o_rd2 <= r_mem[i_ra2];
      if (i_we) r_mem[i_wa] <= i_wd;
    end
  end
endmodule

// File: rtl/rb_alu_core.sv
// rb_alu_core: 4-cycle register-file ALU; clk/rst plus rb_alu_if slave bus (request in, busy/aluout/cb/zf/done out)
module rb_alu_core
  import rb_alu_pkg::*;
#(
  parameter int DW = 16,
  parameter int NREG = 16
) (
  input logic   clk,
  input logic   rst,
  rb_alu_if.slave bus
);
  localparam int AW = $clog2(NREG);
  state_t        r_state;
  logic [3:0]    r_op;
  logic [AW-1:0] r_rd, r_rs;
  logic [DW-1:0] r_imm;
  logic          r_use_imm, r_cin;
  logic [DW:0]   r_res, w_res, w_a, w_b, w_c;
  logic [DW-1:0] w_rd1, w_rd2, w_op2;
  logic          w_we;
  assign w_op2 = r_use_imm ? r_imm : w_rd2;
  assign w_a = {1'b0, w_rd1};
  assign w_b = {1'b0, w_op2};
  assign w_c = (DW+1)'(r_cin);
  assign w_we = r_state == S_WB && r_op != OP_READ && r_op != OP_CMP;
  rb_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (r_rd),
    .i_ra2 (r_rs),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (w_we),
    .i_wa  (r_rd),
    .i_wd  (r_res[DW-1:0])
  );
  // bit DW of the result is the carry/borrow for every opcode
  always_comb begin
    case (r_op)
      OP_LOAD:         w_res = {1'b0, r_imm};
      OP_ADD:          w_res = w_a + w_b;
      OP_ADC:          w_res = w_a + w_b + w_c;
      OP_SUB, OP_CMP:  w_res = w_a - w_b;
      OP_SBB:          w_res = w_a - w_b - w_c;
      OP_AND:          w_res = w_a & w_b;
      OP_OR:           w_res = w_a | w_b;
      OP_XOR:          w_res = w_a ^ w_b;
      OP_NOT:          w_res = {1'b0, ~w_rd1};
      OP_SHL1:         w_res = {w_rd1, 1'b0};
      OP_SHR1:         w_res = {w_rd1[0], 1'b0, w_rd1[DW-1:1]};
      OP_INC:          w_res = w_a + (DW+1)'(1);
      OP_DEC:          w_res = w_a - (DW+1)'(1);
      OP_MOV:          w_res = w_b;
      default:         w_res = w_a;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_res      <= '0;
      bus.busy   <= 1'b0;
      bus.aluout <= '0;
      bus.cb     <= 1'b0;
      bus.zf     <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_op      <= bus.opcode;
          r_rd      <= bus.rd;
          r_rs      <= bus.rs;
          r_imm     <= bus.imm;
          r_use_imm <= bus.use_imm;
          r_cin     <= bus.cin;
          bus.busy  <= 1'b1;
          r_state   <= S_RD;
        end
        S_RD: r_state <= S_EX;
        S_EX: begin
          r_res   <= w_res;
          r_state <= S_WB;
        end
        S_WB: begin
          bus.aluout <= r_res[DW-1:0];
          bus.cb     <= r_res[DW];
          bus.zf     <= r_res[DW-1:0] == '0;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rb_alu_core.sv
// tb_rb_alu_core: directed checks of rb_alu_core at DW=16/NREG=16 and DW=32/NREG=8
module tb_rb_alu_core;
  import rb_alu_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic cur = 0;
  logic a_start = 0, b_start = 0;
  logic [3:0] t_op = 0, t_rd = 0, t_rs = 0;
  logic [31:0] t_imm = 0;
  logic t_ui = 0, t_cin = 0;
  rb_alu_if #(.DW(16), .AW(4)) ia ();
  rb_alu_if #(.DW(32), .AW(3)) ib ();
  assign ia.start = a_start;
  assign ia.opcode = t_op;
  assign ia.rd = t_rd;
  assign ia.rs = t_rs;
  assign ia.imm = t_imm[15:0];
  assign ia.use_imm = t_ui;
  assign ia.cin = t_cin;
  assign ib.start = b_start;
  assign ib.opcode = t_op;
  assign ib.rd = t_rd[2:0];
  assign ib.rs = t_rs[2:0];
  assign ib.imm = t_imm;
  assign ib.use_imm = t_ui;
  assign ib.cin = t_cin;
  rb_alu_core #(.DW(16), .NREG(16)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  rb_alu_core #(.DW(32), .NREG(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  wire [31:0] o_out = cur ? ib.aluout : {16'h0, ia.aluout};
  wire o_cb = cur ? ib.cb : ia.cb;
  wire o_zf = cur ? ib.zf : ia.zf;
  wire o_done = cur ? ib.done : ia.done;
  wire o_busy = cur ? ib.busy : ia.busy;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [3:0] opc, input logic [3:0] rd_, input logic [3:0] rs_, input logic [31:0] imm_, input logic ui, input logic ci);
    @(negedge clk);
    t_op = opc; t_rd = rd_; t_rs = rs_; t_imm = imm_; t_ui = ui; t_cin = ci;
    if (cur) b_start = 1; else a_start = 1;
    @(posedge clk);
    #1;
    a_start = 0; b_start = 0;
    t_op = ~t_op; t_rd = ~t_rd; t_rs = ~t_rs; t_imm = ~t_imm; t_ui = ~t_ui; t_cin = ~t_cin;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("done timing", 32'(o_done), 32'(k == 4));
      chk("busy timing", 32'(o_busy), 32'(k != 4));
    end
  endtask
  task automatic ex(input string tag, input logic [3:0] opc, input logic [3:0] rd_, input logic [3:0] rs_, input logic [31:0] imm_, input logic ui, input logic ci, input logic [31:0] eo, input logic ecb);
    op(opc, rd_, rs_, imm_, ui, ci);
    chk({tag, " aluout"}, o_out, eo);
    chk({tag, " cb"}, 32'(o_cb), 32'(ecb));
    chk({tag, " zf"}, 32'(o_zf), 32'(eo == 0));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(ia.busy), 0);
    chk("rst done", 32'(ia.done), 0);
    chk("rst aluout", 32'(ia.aluout), 0);
    chk("rst cb", 32'(ia.cb), 0);
    chk("rst zf", 32'(ia.zf), 0);
    chk("rst b busy", 32'(ib.busy), 0);
    chk("rst b aluout", ib.aluout, 0);
    rst = 0;
    ex("load r3", OP_LOAD, 3, 0, 32'h1234, 0, 0, 32'h1234, 0);
    ex("read r3", OP_READ, 3, 0, 0, 0, 0, 32'h1234, 0);
    ex("load r1", OP_LOAD, 1, 0, 32'hFFFF, 0, 0, 32'hFFFF, 0);
    ex("add wrap", OP_ADD, 1, 0, 32'h0001, 1, 0, 32'h0000, 1);
    ex("read r1", OP_READ, 1, 0, 0, 0, 0, 32'h0000, 0);
    ex("load r2", OP_LOAD, 2, 0, 32'h0005, 0, 0, 32'h0005, 0);
    ex("cmp", OP_CMP, 2, 0, 32'h0007, 1, 0, 32'hFFFE, 1);
    ex("read r2", OP_READ, 2, 0, 0, 0, 0, 32'h0005, 0);
    ex("load r5", OP_LOAD, 5, 0, 32'h0003, 0, 0, 32'h0003, 0);
    ex("sub reg", OP_SUB, 5, 2, 0, 0, 0, 32'hFFFE, 1);
    ex("read r5", OP_READ, 5, 0, 0, 0, 0, 32'hFFFE, 0);
    ex("add rd=rs", OP_ADD, 2, 2, 0, 0, 0, 32'h000A, 0);
    ex("load r6", OP_LOAD, 6, 0, 32'h8001, 0, 0, 32'h8001, 0);
    ex("shl1", OP_SHL1, 6, 0, 0, 0, 0, 32'h0002, 1);
    ex("shr1", OP_SHR1, 6, 0, 0, 0, 0, 32'h0001, 0);
    ex("load r7", OP_LOAD, 7, 0, 32'hFFFF, 0, 0, 32'hFFFF, 0);
    ex("inc wrap", OP_INC, 7, 0, 0, 0, 0, 32'h0000, 1);
    ex("dec wrap", OP_DEC, 8, 0, 0, 0, 0, 32'hFFFF, 1);
    ex("load r9", OP_LOAD, 9, 0, 32'h0F0F, 0, 0, 32'h0F0F, 0);
    ex("xor", OP_XOR, 9, 0, 32'h00FF, 1, 0, 32'h0FF0, 0);
    ex("not", OP_NOT, 9, 0, 0, 0, 0, 32'hF00F, 0);
    ex("and", OP_AND, 9, 0, 32'h0FF0, 1, 0, 32'h0000, 0);
    ex("or", OP_OR, 9, 0, 32'h1234, 1, 0, 32'h1234, 0);
    ex("load r10", OP_LOAD, 10, 0, 32'h0010, 0, 0, 32'h0010, 0);
    ex("sbb", OP_SBB, 10, 0, 32'h0001, 1, 1, 32'h000E, 0);
    ex("adc", OP_ADC, 10, 0, 32'hFFF1, 1, 1, 32'h0000, 1);
    ex("mov", OP_MOV, 11, 3, 0, 0, 0, 32'h1234, 0);
    ex("sbb borrow", OP_SBB, 13, 0, 32'h0000, 1, 1, 32'hFFFF, 1);
    @(negedge clk);
    t_op = OP_READ; t_rd = 3; t_ui = 0; a_start = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("hold busy", 32'(ia.busy), 32'(k % 4 != 3));
      chk("hold done", 32'(ia.done), 32'(k % 4 == 3));
      if (k == 3) begin
        chk("hold op0", 32'(ia.aluout), 32'h1234);
        t_op = OP_LOAD; t_rd = 12; t_imm = 32'h55; t_ui = 1;
      end
      if (k == 7) begin
        chk("hold op1", 32'(ia.aluout), 32'h55);
        t_op = OP_READ;
      end
      if (k == 11) begin
        chk("hold op2", 32'(ia.aluout), 32'h55);
        a_start = 0;
      end
    end
    ex("load r4", OP_LOAD, 4, 0, 32'h00AA, 0, 0, 32'h00AA, 0);
    @(negedge clk);
    t_op = OP_ADD; t_rd = 4; t_imm = 1; t_ui = 1; a_start = 1;
    @(posedge clk);
    #1 a_start = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort done", 32'(ia.done), 0);
      chk("abort busy", 32'(ia.busy), 0);
    end
    chk("abort aluout", 32'(ia.aluout), 0);
    chk("abort cb", 32'(ia.cb), 0);
    chk("abort zf", 32'(ia.zf), 0);
    ex("read r4", OP_READ, 4, 0, 0, 0, 0, 32'h0000, 0);
    ex("read r3 cleared", OP_READ, 3, 0, 0, 0, 0, 32'h0000, 0);
    cur = 1;
    ex("b load r7", OP_LOAD, 7, 0, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 0);
    ex("b adc", OP_ADC, 7, 0, 32'h0, 1, 1, 32'h0, 1);
    ex("b load r1", OP_LOAD, 1, 0, 32'h1, 0, 0, 32'h1, 0);
    ex("b shr1", OP_SHR1, 1, 0, 0, 0, 0, 32'h0, 1);
    ex("b load r2", OP_LOAD, 2, 0, 32'h80000000, 0, 0, 32'h80000000, 0);
    ex("b shl1", OP_SHL1, 2, 0, 0, 0, 0, 32'h0, 1);
    ex("b read r7", OP_READ, 7, 0, 0, 0, 0, 32'h0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rb_alu_core.md
RB_ALU_CORE -- requirements
Module: rb_alu_core

Interface
REQ-001 Parameter DW, default 16, data/register width in bits (legal values >= 4).
REQ-002 Parameter NREG, default 16, number of registers (power of two, >= 2); AW = clog2(NREG) is derived, not overridable.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 opcode  input  4  operation select (REQ-013).
REQ-007 rd  input  AW  destination and first-operand register index.
REQ-008 rs  input  AW  second-operand register index.
REQ-009 imm  input  DW  immediate second operand.
REQ-010 use_imm  input  1  1: op2 = imm; 0: op2 = R[rs].
REQ-011 cin  input  1  carry/borrow in for ADC/SBB.
REQ-012 busy  output  1, aluout  output  DW, cb  output  1, zf  output  1 (aluout == 0), done  output  1 (one-cycle completion pulse); all registered.

Function
REQ-013 Opcodes, op1 = R[rd]: 0 LOAD (imm), 1 ADD, 2 ADC (+cin), 3 SUB, 4 SBB (-cin), 5 AND, 6 OR, 7 XOR, 8 NOT op1, 9 SHL1 op1, 10 SHR1 op1, 11 INC op1, 12 DEC op1, 13 MOV op2, 14 READ op1, 15 CMP (op1-op2).
REQ-014 FSM states IDLE, RD, EX, WB; IDLE->RD when start=1, RD->EX, EX->WB, WB->IDLE unconditionally.
REQ-015 At the accepting edge N, opcode/rd/rs/imm/use_imm/cin are captured; later input changes have no effect on that operation.
REQ-016 Edge N+1 latches op1/op2 from the register file; edge N+2 latches result and carry; edge N+3 writes R[rd] and updates aluout/cb/zf, and asserts done for exactly one cycle.
REQ-017 busy = 1 in every state other than IDLE; start while busy is ignored (not queued); earliest next accept is edge N+4.
REQ-018 Arithmetic uses DW+1 bits; ADD/ADC/INC: cb = carry out; SUB/SBB/DEC/CMP: cb = borrow (1 when unsigned result underflows).
REQ-019 SHL1: cb = op1[DW-1], LSB filled 0; SHR1: cb = op1[0], MSB filled 0; LOAD/AND/OR/XOR/NOT/MOV/READ: cb = 0.
REQ-020 INC of all-ones wraps to 0 with cb=1; DEC of 0 wraps to all-ones with cb=1.
REQ-021 READ and CMP drive aluout/cb/zf but do not write the register file; all other opcodes write R[rd].
REQ-022 rd == rs is legal; both operands read the pre-operation value.
REQ-023 aluout/cb/zf hold their values between operations; done is 0 except in the WB-following cycle.

Reset
REQ-024 rst=1 at a rising edge forces state to IDLE, all NREG registers to 0, and aluout, cb, zf, done, busy to 0, from any state.
REQ-025 Reset in RD/EX/WB aborts the operation: no write, no done pulse.
REQ-026 rst has priority over start on the same edge.

Structure
REQ-027 Package rb_alu_pkg holds the 4-bit opcode constants and the FSM state encoding; DW/NREG stay module parameters.
REQ-028 Sub-module rb_regfile (params DW, NREG): two registered read ports, one synchronous write port, synchronous reset clearing all entries.
REQ-029 ALU datapath is combinational inside rb_alu_core, registered at the EX->WB edge.

Verification
REQ-030 DW=16: reset, LOAD rd=3 imm=0x1234 -> done at N+3, aluout=0x1234, cb=0; then READ rd=3 -> aluout=0x1234, zf=0.
REQ-031 R1=0xFFFF, ADD rd=1 use_imm imm=0x0001 -> aluout=0x0000, cb=1, zf=1; READ rd=1 -> 0x0000.
REQ-032 R2=0x0005, CMP rd=2 imm=0x0007 -> aluout=0xFFFE, cb=1; READ rd=2 -> 0x0005 (unchanged).
REQ-033 start held high continuously with different opcodes -> accepts only at N, N+4, N+8; busy low only in accept cycles; one done per op.
REQ-034 LOAD R4=0x00AA then ADD R4, and rst=1 during EX -> no done, aluout=0, R4=0 (READ rd=4 returns 0).
REQ-035 DW=32, NREG=8: R7=0xFFFFFFFF, ADC rd=7 imm=0 cin=1 -> aluout=0, cb=1, zf=1; SHR1 on 0x00000001 -> 0, cb=1.
